// File: rtl/parity_rx.sv
// UART-style serial receiver: start, 8 data bits LSB first, parity, stop.
// Mid-bit sampling off a 2-flop synchronized line, with a saturating error counter.
module parity_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_cnt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       par_err;
  } rx_rsp_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_prev_q;
  logic          armed_q, armed_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  rx_rsp_t       rsp_q, rsp_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          err_inc;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    par_d       = par_q;
    rsp_d       = rsp_q;
    armed_d     = armed_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // after a framing error the line must be seen high before a new start counts
        if (rx_s) armed_d = 1'b1;
        if (armed_q && rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sr_d  = {rx_s, sr_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            rx_valid_d    = 1'b1;
            rsp_d.data    = sr_q;
            rsp_d.par_err = ^sr_q ^ par_q ^ PARITY_ODD;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // counts off the registered pulses, so a clear in the pulse cycle wins
  always_comb begin
    err_inc   = (rx_valid_q && rsp_q.par_err) || frame_err_q;
    err_cnt_d = err_cnt_q;
    if (err_clr)                           err_cnt_d = '0;
    else if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      armed_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      rsp_q       <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync_q      <= {sync_q[0], rx_in};
      rx_prev_q   <= rx_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      rsp_q       <= rsp_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_data    = rsp_q.data;
  assign parity_err = rsp_q.par_err;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_parity_rx.sv
// Scoreboard bench for parity_rx: even and odd parity instances share one serial line.
module tb_parity_rx;
  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 10 * CPB;

  typedef struct {
    bit         fe;
    logic [7:0] data;
    bit         perr;
    int         cyc;
  } exp_t;

  logic       clk, rst_n, rx, err_clr;
  logic [7:0] rx_data, err_cnt, o_rx_data, o_err_cnt;
  logic       rx_valid, parity_err, frame_err, busy;
  logic       o_rx_valid, o_parity_err, o_frame_err, o_busy;

  int   checks, errors, cyc, v_cnt, f_cnt, o_v_cnt;
  exp_t sb[$];
  exp_t e;
  logic [7:0] exp_err, exp_data;
  bit         exp_perr;

  parity_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt)
  );

  parity_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .rx_in(rx), .err_clr(err_clr),
    .rx_data(o_rx_data), .rx_valid(o_rx_valid), .parity_err(o_parity_err),
    .frame_err(o_frame_err), .busy(o_busy), .err_cnt(o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pop the scoreboard whenever the even-parity receiver reports a frame
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid && frame_err) begin
        checks++; errors++;
        $display("FAIL pulse_overlap rx_valid=1 frame_err=1 at cyc %0d", cyc);
      end
      if (rx_valid || frame_err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse valid=%0b ferr=%0b at cyc %0d", rx_valid, frame_err, cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (frame_err !== e.fe) begin errors++; $display("FAIL sb_kind frame_err=%0b want %0b", frame_err, e.fe); end
          checks++;
          if (rx_data !== e.data) begin errors++; $display("FAIL sb_data got %h want %h", rx_data, e.data); end
          checks++;
          if (parity_err !== e.perr) begin errors++; $display("FAIL sb_perr got %0b want %0b", parity_err, e.perr); end
          checks++;
          if (cyc !== e.cyc) begin errors++; $display("FAIL sb_latency pulse at cyc %0d want %0d", cyc, e.cyc); end
        end
      end
      if (rx_valid) v_cnt++;
      if (frame_err) f_cnt++;
      if (o_rx_valid) o_v_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle_line(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drives one frame; abort_at >= 0 returns early at that cycle without a scoreboard entry
  task automatic send_frame(input logic [7:0] d, input bit par, input bit stp,
                            input bit clr, input int abort_at);
    logic [10:0] bits;
    bit          perr;
    int          t0;
    bits = {stp, par, d, 1'b0};
    perr = ^d ^ par;
    @(posedge clk); #1;
    t0 = cyc;
    if (abort_at < 0) begin
      if (stp) sb.push_back('{1'b0, d, perr, t0 + LAT});
      else     sb.push_back('{1'b1, exp_data, exp_perr, t0 + LAT});
      if (stp) begin exp_data = d; exp_perr = perr; end
      if (clr) exp_err = 8'h00;
      else if ((!stp || perr) && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
    for (int j = 0; j < 11 * CPB; j++) begin
      if (j == abort_at) return;
      rx      = bits[j / CPB];
      err_clr = clr && (j == LAT);
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; err_clr = 1'b0;
    exp_err = 8'h00; exp_data = 8'h00; exp_perr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (err_cnt !== 8'h00)   begin errors++; $display("FAIL rst_err_cnt got %h want 00", err_cnt); end
    rst_n = 1'b1;
    idle_line(CPB);
  endtask

  task automatic test_basic;
    int v0, ov0;
    v0 = v_cnt; ov0 = o_v_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
    idle_line(CPB);
    checks++; if (v_cnt - v0 !== 1)      begin errors++; $display("FAIL basic_pulses got %0d want 1", v_cnt - v0); end
    checks++; if (rx_data !== 8'hA5)     begin errors++; $display("FAIL basic_data got %h want a5", rx_data); end
    checks++; if (parity_err !== 1'b0)   begin errors++; $display("FAIL basic_perr got %b want 0", parity_err); end
    checks++; if (err_cnt !== exp_err)   begin errors++; $display("FAIL basic_err_cnt got %0d want %0d", err_cnt, exp_err); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
    checks++; if (o_v_cnt - ov0 !== 1)   begin errors++; $display("FAIL basic_odd_pulses got %0d want 1", o_v_cnt - ov0); end
    checks++; if (o_parity_err !== 1'b1) begin errors++; $display("FAIL basic_odd_perr got %b want 1", o_parity_err); end
  endtask

  task automatic test_parity;
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, -1);
    idle_line(CPB);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_perr got %b want 1", parity_err); end
    checks++; if (err_cnt !== 8'd1)    begin errors++; $display("FAIL par_bad_cnt got %0d want 1", err_cnt); end
    send_frame(8'h03, 1'b0, 1'b1, 1'b0, -1);
    idle_line(CPB);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_perr got %b want 0", parity_err); end
    checks++; if (rx_data !== 8'h03)   begin errors++; $display("FAIL par_good_data got %h want 03", rx_data); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL par_good_cnt got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_frame_err;
    int v0, f0, bcnt;
    v0 = v_cnt; f0 = f_cnt; bcnt = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    // line stays low after the bad stop bit: no new frame may start
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk); if (busy) bcnt++;
      @(posedge clk); #1;
    end
    idle_line(CPB);
    checks++; if (bcnt !== 0)          begin errors++; $display("FAIL ferr_rearm busy_cycles got %0d want 0", bcnt); end
    checks++; if (f_cnt - f0 !== 1)    begin errors++; $display("FAIL ferr_pulses got %0d want 1", f_cnt - f0); end
    checks++; if (v_cnt - v0 !== 0)    begin errors++; $display("FAIL ferr_valid got %0d want 0", v_cnt - v0); end
    checks++; if (rx_data !== 8'h03)   begin errors++; $display("FAIL ferr_data got %h want 03", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ferr_perr_hold got %b want 0", parity_err); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL ferr_cnt got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_glitch;
    int v0, f0, bcnt;
    v0 = v_cnt; f0 = f_cnt; bcnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 4 * CPB; i++) begin
      if (i == CPB / 4) rx = 1'b1;
      @(negedge clk); if (busy) bcnt++;
      @(posedge clk); #1;
    end
    checks++; if (bcnt !== HALF)               begin errors++; $display("FAIL glitch_busy cycles got %0d want %0d", bcnt, HALF); end
    checks++; if (v_cnt - v0 + f_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", v_cnt - v0 + f_cnt - f0); end
    checks++; if (busy !== 1'b0)               begin errors++; $display("FAIL glitch_idle busy got %b want 0", busy); end
  endtask

  task automatic test_saturate;
    for (int n = 0; n < 260; n++) begin
      send_frame(8'h01, 1'b0, 1'b1, 1'b0, -1);
      idle_line(CPB / 2);
    end
    idle_line(CPB);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", err_cnt); end
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, -1);
    idle_line(CPB);
    checks++; if (err_cnt !== 8'd0)   begin errors++; $display("FAIL sat_clear got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_midframe;
    int v0;
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, -1);
    idle_line(CPB);
    v0 = v_cnt;
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 5 * CPB + HALF);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL mid_rst_data got %h want 00", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL mid_rst_perr got %b want 0", parity_err); end
    checks++; if (err_cnt !== 8'h00)   begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", err_cnt); end
    checks++; if ((rx_valid | frame_err) !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses got %b want 0", rx_valid | frame_err); end
    rx = 1'b1;
    exp_err = 8'h00; exp_data = 8'h00; exp_perr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_line(3 * CPB);
    checks++; if (v_cnt - v0 !== 0)    begin errors++; $display("FAIL mid_rst_ghost got %0d want 0", v_cnt - v0); end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    idle_line(CPB);
    checks++; if (rx_data !== 8'h5A)   begin errors++; $display("FAIL post_rst_data got %h want 5a", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL post_rst_perr got %b want 0", parity_err); end
  endtask

  task automatic test_odd;
    int ov0;
    ov0 = o_v_cnt;
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, -1);
    idle_line(CPB);
    checks++; if (o_v_cnt - ov0 !== 1)   begin errors++; $display("FAIL odd_pulses got %0d want 1", o_v_cnt - ov0); end
    checks++; if (o_rx_data !== 8'h00)   begin errors++; $display("FAIL odd_data got %h want 00", o_rx_data); end
    checks++; if (o_parity_err !== 1'b0) begin errors++; $display("FAIL odd_perr got %b want 0", o_parity_err); end
    checks++; if (parity_err !== 1'b1)   begin errors++; $display("FAIL odd_even_view_perr got %b want 1", parity_err); end
    checks++; if (err_cnt !== exp_err)   begin errors++; $display("FAIL odd_even_cnt got %0d want %0d", err_cnt, exp_err); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; v_cnt = 0; f_cnt = 0; o_v_cnt = 0;
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_glitch;
    test_saturate;
    test_reset_midframe;
    test_odd;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain left %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
